// File: rtl/sparse_pair_selector.sv
// ============================================================================
// sparse_pair_selector
//
// Sparse-match front end for the PE input path. It walks a range of
// sparsemap segments and ANDs the IFM and filter sparsemaps of each segment.
// For every matching bit, in ascending bit order, it emits the nonzero-data
// indices of the matching IFM byte and filter byte. It only drives read
// addresses and holds no data bytes.
//
// Optional feature: define SPARSE_SEL_ABORT_EN to add abort_i. When abort_i
// is high in any non-IDLE state, the run is cancelled at the next edge and
// done_o is not pulsed.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              one-cycle run start, honoured only while idle
//   seg_first_i/last_i   inclusive segment range, may wrap modulo SEG_NUM
//   ifm_base_i/fil_base_i  nonzero index of bit 0 of the first segment
//   map_addr_o           registered segment address to the sparsemap buffers
//   ifm_map_i/fil_map_i  sparsemaps at map_addr_o (combinational read)
//   pair_valid_o/pair_ready_i  output handshake
//   ifm_idx_o/fil_idx_o  matched nonzero-data indices
//   busy_o, done_o       run in progress / one-cycle completion pulse
//   abort_i              (SPARSE_SEL_ABORT_EN only) cancel the current run
//
// Handshake: a pair transfers on a rising edge where pair_valid_o and
// pair_ready_i are both high. While pair_valid_o is high and pair_ready_i is
// low, ifm_idx_o and fil_idx_o are held stable. pair_valid_o falls after a
// transfer unless a new pair is issued on the same edge.
// ============================================================================
module sparse_pair_selector #(
    parameter int MAP_W    = 32,
    parameter int SEG_NUM  = 4,
    localparam int SEG_AW  = $clog2(SEG_NUM),
    parameter int IDX_W    = $clog2(MAP_W*SEG_NUM)+1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [SEG_AW-1:0] seg_first_i,
    input  logic [SEG_AW-1:0] seg_last_i,
    input  logic [IDX_W-1:0]  ifm_base_i,
    input  logic [IDX_W-1:0]  fil_base_i,
    output logic [SEG_AW-1:0] map_addr_o,
    input  logic [MAP_W-1:0]  ifm_map_i,
    input  logic [MAP_W-1:0]  fil_map_i,
    output logic              pair_valid_o,
    input  logic              pair_ready_i,
    output logic [IDX_W-1:0]  ifm_idx_o,
    output logic [IDX_W-1:0]  fil_idx_o,
    output logic              busy_o,
`ifdef SPARSE_SEL_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SCAN  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [SEG_AW-1:0] SEG_ONE = 1;
    localparam logic [MAP_W-1:0]  MAP_ONE = 1;

    function automatic logic [IDX_W-1:0] popcnt(input logic [MAP_W-1:0] v);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAP_W; i++) begin
            c = c + {{(IDX_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_t            r_state;
    logic [SEG_AW-1:0] r_seg;
    logic [SEG_AW-1:0] r_seg_last;
    logic [IDX_W-1:0]  r_ifm_base;
    logic [IDX_W-1:0]  r_fil_base;
    logic [MAP_W-1:0]  r_res;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [IDX_W-1:0]  r_ifm_idx;
    logic [IDX_W-1:0]  r_fil_idx;

    logic [MAP_W-1:0]  w_and;
    logic [MAP_W-1:0]  w_lsb;
    logic [MAP_W-1:0]  w_below;
    logic [MAP_W-1:0]  w_res_next;
    logic              w_free;
    logic              w_at_last;
    logic              w_abort;
    logic [IDX_W-1:0]  w_ifm_cnt;
    logic [IDX_W-1:0]  w_fil_cnt;
    logic [IDX_W-1:0]  w_ifm_pre;
    logic [IDX_W-1:0]  w_fil_pre;

    assign w_and      = ifm_map_i & fil_map_i;
    // Two's-complement trick isolates the lowest set bit of the residual;
    // subtracting one from it gives the mask of all bits strictly below it,
    // which is what the prefix popcount needs.
    assign w_lsb      = r_res & (~r_res + MAP_ONE);
    assign w_below    = w_lsb - MAP_ONE;
    assign w_res_next = r_res & ~w_lsb;
    // The output slot can take a new pair when it is empty or being drained.
    assign w_free     = !r_valid || pair_ready_i;
    assign w_at_last  = (r_seg == r_seg_last);
    assign w_ifm_cnt  = popcnt(ifm_map_i);
    assign w_fil_cnt  = popcnt(fil_map_i);
    assign w_ifm_pre  = popcnt(ifm_map_i & w_below);
    assign w_fil_pre  = popcnt(fil_map_i & w_below);

`ifdef SPARSE_SEL_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_seg      <= '0;
            r_seg_last <= '0;
            r_ifm_base <= '0;
            r_fil_base <= '0;
            r_res      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ifm_idx  <= '0;
            r_fil_idx  <= '0;
        end else begin
            r_done <= 1'b0;
            // An accepted pair leaves the slot unless a new one is issued below.
            if (r_valid && pair_ready_i) begin
                r_valid <= 1'b0;
            end

            if (w_abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_seg      <= seg_first_i;
                            r_seg_last <= seg_last_i;
                            r_ifm_base <= ifm_base_i;
                            r_fil_base <= fil_base_i;
                            r_busy     <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end

                    S_LOAD: begin
                        r_res <= w_and;
                        if (w_and != '0) begin
                            r_state <= S_SCAN;
                        end else if (!w_at_last) begin
                            // Skip an empty segment: bases move past all of
                            // its nonzero bytes.
                            r_ifm_base <= r_ifm_base + w_ifm_cnt;
                            r_fil_base <= r_fil_base + w_fil_cnt;
                            r_seg      <= r_seg + SEG_ONE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end

                    S_SCAN: begin
                        // Without room in the output slot everything holds.
                        if (w_free) begin
                            r_ifm_idx <= r_ifm_base + w_ifm_pre;
                            r_fil_idx <= r_fil_base + w_fil_pre;
                            r_valid   <= 1'b1;
                            r_res     <= w_res_next;
                            if (w_res_next == '0) begin
                                if (w_at_last) begin
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_ifm_base <= r_ifm_base + w_ifm_cnt;
                                    r_fil_base <= r_fil_base + w_fil_cnt;
                                    r_seg      <= r_seg + SEG_ONE;
                                    r_state    <= S_LOAD;
                                end
                            end
                        end
                    end

                    S_DRAIN: begin
                        // Completion waits for the last pair to be taken.
                        if (w_free) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign map_addr_o   = r_seg;
    assign pair_valid_o = r_valid;
    assign ifm_idx_o    = r_ifm_idx;
    assign fil_idx_o    = r_fil_idx;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
